unified_mem_arbiter: RTL

//  Shares one single-ported unified instruction/data memory between the fetch stage (IF, read-only)
//  and the memory stage (D, load/store) of the rv32i pipeline. Grants one requester at a time and

---
 rtl/unified_mem_arbiter_pkg.sv | 11 +
 rtl/unified_mem_arbiter.sv | 128 ++++++++++++
 2 files changed

// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types for the unified instruction/data memory arbiter.
// The state encoding lives here so other pipeline blocks can decode arbiter state.
package unified_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_IF   = 2'd1,
        ARB_D    = 2'd2
    } arb_state_t;

endpackage

// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-ported unified memory between instruction fetch and the data stage,
// holding each memory request until acknowledged and routing the response back to its owner.
module unified_mem_arbiter
    import unified_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_D_STREAK = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    input  logic                if_flush,
    output logic                if_valid,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_stall,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_valid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_stall,
    output logic                mem_req,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int BE_W = DATA_W / 8;
    localparam int SW   = $clog2(MAX_D_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

    arb_state_t     state;
    arb_state_t     state_next;
    logic [SW-1:0]  streak;
    logic           drop;
    logic           grant_if;
    logic           grant_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A flushing fetch is never granted since its address is already stale; once D has
    // won MAX_D_STREAK times in a row against a waiting fetch, the fetch takes priority.
    always_comb begin
        state_next = state;
        grant_if   = 1'b0;
        grant_d    = 1'b0;
        case (state)
            ARB_IDLE: begin
                grant_if = if_req && !if_flush && (!d_req || (streak == STREAK_MAX));
                grant_d  = d_req && !grant_if;
                if (grant_if) begin
                    state_next = ARB_IF;
                end else if (grant_d) begin
                    state_next = ARB_D;
                end
            end
            ARB_IF, ARB_D: begin
                if (mem_ack) begin
                    state_next = ARB_IDLE;
                end
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_we    <= 1'b0;
            mem_be    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (grant_d) begin
            mem_we    <= d_we;
            mem_be    <= d_be;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
        end else if (grant_if) begin
            mem_we    <= 1'b0;
            mem_be    <= {BE_W{1'b1}};
            mem_addr  <= if_addr;
        end
    end

    // The streak only counts D wins while a fetch is actually waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            streak <= '0;
        end else if (state == ARB_IDLE) begin
            if (!if_req || grant_if) begin
                streak <= '0;
            end else if (grant_d && (streak != STREAK_MAX)) begin
                streak <= streak + SW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop <= 1'b0;
        end else if (mem_ack) begin
            drop <= 1'b0;
        end else if ((state == ARB_IF) && if_flush) begin
            drop <= 1'b1;
        end
    end

    assign mem_req  = (state != ARB_IDLE);
    assign if_valid = mem_ack && (state == ARB_IF) && !drop && !if_flush;
    assign d_valid  = mem_ack && (state == ARB_D);
    assign if_rdata = mem_rdata;
    assign d_rdata  = mem_rdata;
    assign if_stall = if_req && !if_valid;
    assign d_stall  = d_req && !d_valid;

endmodule
